// File: rtl/trigger_pulse_generator.sv
// Programmable trigger-pulse source. A start command begins a burst: an
// optional delay, then pulse_count rectangular pulses with programmable high
// and low widths. Each pulse starts with a clean 0->1 edge, so downstream
// rising-edge detectors see one event per pulse.
//
// Handshake: start and abort are single-cycle requests sampled on clk. start
// is accepted only in IDLE without a simultaneous abort. abort acts only while
// a burst is running. There is no back-pressure.
module trigger_pulse_generator #(
    parameter int CNT_W = 32,
    parameter int N_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] delay,
    input  logic [CNT_W-1:0] high_cycles,
    input  logic [CNT_W-1:0] low_cycles,
    input  logic [N_W-1:0]   pulse_count,
    output logic             pulse_out,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [N_W-1:0]   pulses_sent
);

    typedef enum logic [1:0] {IDLE, DELAY, HIGH, LOW} state_t;

    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);
    localparam logic [N_W-1:0]   ONE_N = N_W'(1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] lat_high_m1, lat_high_m1_n;
    logic [CNT_W-1:0] lat_low_m1, lat_low_m1_n;
    logic [N_W-1:0]   lat_count, lat_count_n;
    logic [N_W-1:0]   sent_n;
    logic             done_n, aborted_n;

    // A width of 0 behaves like 1; the counters run from (width-1) down to 0,
    // so the widest setting never overflows.
    function automatic logic [CNT_W-1:0] width_m1(input logic [CNT_W-1:0] v);
        return (v == '0) ? '0 : v - ONE_C;
    endfunction

    // pulses_sent saturates at its maximum instead of wrapping.
    function automatic logic [N_W-1:0] sat_inc(input logic [N_W-1:0] v);
        return (v == '1) ? v : v + ONE_N;
    endfunction

    // Next-state logic: phase sequencing, counter reloads and strobe requests.
    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        lat_high_m1_n = lat_high_m1;
        lat_low_m1_n  = lat_low_m1;
        lat_count_n   = lat_count;
        sent_n        = pulses_sent;
        done_n        = 1'b0;
        aborted_n     = 1'b0;

        case (state)
            IDLE: begin
                if (start && !abort) begin
                    lat_high_m1_n = width_m1(high_cycles);
                    lat_low_m1_n  = width_m1(low_cycles);
                    lat_count_n   = pulse_count;
                    sent_n        = '0;
                    if (pulse_count == '0) begin
                        done_n = 1'b1;
                    end else if (delay == '0) begin
                        state_n = HIGH;
                        cnt_n   = width_m1(high_cycles);
                        sent_n  = ONE_N;
                    end else begin
                        state_n = DELAY;
                        cnt_n   = delay - ONE_C;
                    end
                end
            end
            DELAY: begin
                if (cnt == '0) begin
                    state_n = HIGH;
                    cnt_n   = lat_high_m1;
                    sent_n  = sat_inc(pulses_sent);
                end else begin
                    cnt_n = cnt - ONE_C;
                end
            end
            HIGH: begin
                if (cnt == '0) begin
                    if (pulses_sent < lat_count) begin
                        state_n = LOW;
                        cnt_n   = lat_low_m1;
                    end else begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                end else begin
                    cnt_n = cnt - ONE_C;
                end
            end
            LOW: begin
                if (cnt == '0) begin
                    state_n = HIGH;
                    cnt_n   = lat_high_m1;
                    sent_n  = sat_inc(pulses_sent);
                end else begin
                    cnt_n = cnt - ONE_C;
                end
            end
            default: state_n = IDLE;
        endcase

        // abort overrides every running phase, including the final HIGH cycle.
        if (state != IDLE && abort) begin
            state_n   = IDLE;
            done_n    = 1'b0;
            aborted_n = 1'b1;
            sent_n    = pulses_sent;
        end
    end

    // State and output registers; outputs decode the next state so that no
    // input reaches an output combinationally.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            lat_high_m1 <= '0;
            lat_low_m1  <= '0;
            lat_count   <= '0;
            pulse_out   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            aborted     <= 1'b0;
            pulses_sent <= '0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            lat_high_m1 <= lat_high_m1_n;
            lat_low_m1  <= lat_low_m1_n;
            lat_count   <= lat_count_n;
            pulse_out   <= (state_n == HIGH);
            busy        <= (state_n != IDLE);
            done        <= done_n;
            aborted     <= aborted_n;
            pulses_sent <= sent_n;
        end
    end

endmodule

// File: tb/tb_trigger_pulse_generator.sv
// Bench for trigger_pulse_generator: directed bursts, a timeline model
// computed from burst arithmetic, and pinned literal expectations.
module tb_trigger_pulse_generator;

    localparam int CNT_W = 32;
    localparam int N_W   = 16;
    localparam int LOG_N = 4096;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [CNT_W-1:0] delay = '0;
    logic [CNT_W-1:0] high_cycles = '0;
    logic [CNT_W-1:0] low_cycles = '0;
    logic [N_W-1:0]   pulse_count = '0;
    logic             pulse_out, busy, done, aborted;
    logic [N_W-1:0]   pulses_sent;

    trigger_pulse_generator #(.CNT_W(CNT_W), .N_W(N_W)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .delay(delay), .high_cycles(high_cycles), .low_cycles(low_cycles),
        .pulse_count(pulse_count), .pulse_out(pulse_out), .busy(busy),
        .done(done), .aborted(aborted), .pulses_sent(pulses_sent)
    );

    // Clock and cycle counter: cycle c runs from posedge c to posedge c+1.
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic log_p [LOG_N];
    logic log_b [LOG_N];
    logic log_d [LOG_N];
    logic log_a [LOG_N];
    logic [N_W-1:0] log_s [LOG_N];
    int edge_cnt = 0;
    logic prev_p = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, got, exp);
        end
    endtask

    // Model: a running burst is described by its first rise, period, high
    // width, count and the cycle in which done appears.
    bit     m_mode = 0;
    longint m_first, m_P, m_H, m_N, m_end;
    longint m_sent = 0, m_done_cyc = -1, m_abort_cyc = -1;

    function automatic longint rises_upto(input longint x);
        longint r;
        if (x < m_first) return 0;
        r = (x - m_first) / m_P + 1;
        return (r > m_N) ? m_N : r;
    endfunction

    always @(posedge clk) begin
        longint c, h, l;
        bit idle_prev;
        cyc = cyc + 1;
        c = cyc;
        idle_prev = !m_mode || (c - 1) >= m_end;
        if (reset) begin
            m_mode = 0; m_sent = 0; m_done_cyc = -1; m_abort_cyc = -1;
        end else begin
            if (m_mode && (c - 1) >= m_end) begin
                m_mode = 0; m_sent = m_N; m_done_cyc = m_end;
            end
            if (!idle_prev && abort) begin
                m_sent = rises_upto(c - 1);
                m_mode = 0;
                m_abort_cyc = c;
            end else if (idle_prev && start && !abort) begin
                if (pulse_count == 0) begin
                    m_mode = 0; m_sent = 0; m_done_cyc = c;
                end else begin
                    h = (high_cycles == 0) ? 1 : longint'(high_cycles);
                    l = (low_cycles == 0) ? 1 : longint'(low_cycles);
                    m_mode  = 1;
                    m_H     = h;
                    m_P     = h + l;
                    m_N     = longint'(pulse_count);
                    m_first = c + longint'(delay);
                    m_end   = m_first + (m_N - 1) * m_P + m_H;
                end
            end
        end
    end

    // Compare process: every cycle after the first reset edge.
    always @(negedge clk) begin
        longint c, k;
        logic e_p, e_b, e_d, e_a;
        longint e_s;
        c = cyc;
        e_p = 0; e_b = 0; e_d = 0; e_a = 0; e_s = m_sent;
        if (m_mode) begin
            if (c < m_first) begin
                e_b = 1; e_s = 0;
            end else if (c < m_end) begin
                k = c - m_first;
                e_b = 1;
                e_p = ((k % m_P) < m_H);
                e_s = k / m_P + 1;
            end else begin
                e_s = m_N; e_d = 1;
            end
        end else begin
            e_d = (c == m_done_cyc);
            e_a = (c == m_abort_cyc);
        end
        if (cyc >= 1) begin
            check("pulse_out", 64'(pulse_out), 64'(e_p));
            check("busy", 64'(busy), 64'(e_b));
            check("done", 64'(done), 64'(e_d));
            check("aborted", 64'(aborted), 64'(e_a));
            check("pulses_sent", 64'(pulses_sent), 64'(e_s));
            if (cyc < LOG_N) begin
                log_p[cyc] = pulse_out; log_b[cyc] = busy; log_d[cyc] = done;
                log_a[cyc] = aborted; log_s[cyc] = pulses_sent;
            end
            // Rising-edge detector on the trigger line, rearmed after each edge.
            if (pulse_out === 1'b1 && prev_p === 1'b0) edge_cnt++;
            prev_p = pulse_out;
        end
    end

    // Driver tasks.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) tick(1);
    endtask

    task automatic drive_start(input int d, input int h, input int l, input int n);
        delay = CNT_W'(d); high_cycles = CNT_W'(h);
        low_cycles = CNT_W'(l); pulse_count = N_W'(n);
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    int s, e0, nd;
    int cfg [3][4] = '{'{1, 1, 3, 4}, '{2, 3, 0, 2}, '{0, 5, 2, 3}};

    initial begin
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
        check("rst_pulse_out", 64'(pulse_out), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_pulses_sent", 64'(pulses_sent), 0);

        // Basic burst with config changed mid-burst.
        s = cyc; e0 = edge_cnt;
        drive_start(3, 2, 1, 3);
        wait_until(s + 2);
        delay = 5; high_cycles = 9; low_cycles = 9; pulse_count = 7;
        wait_until(s + 16);
        check("basic_p3", 64'(log_p[s+3]), 0);
        check("basic_p4", 64'(log_p[s+4]), 1);
        check("basic_p6", 64'(log_p[s+6]), 0);
        check("basic_p11", 64'(log_p[s+11]), 1);
        check("basic_p12", 64'(log_p[s+12]), 0);
        check("basic_b1", 64'(log_b[s+1]), 1);
        check("basic_b12", 64'(log_b[s+12]), 0);
        check("basic_d11", 64'(log_d[s+11]), 0);
        check("basic_d12", 64'(log_d[s+12]), 1);
        check("basic_sent", 64'(log_s[s+12]), 3);
        check("basic_edges", 64'(edge_cnt - e0), 3);

        // Zero widths and zero delay.
        s = cyc;
        drive_start(0, 0, 0, 2);
        wait_until(s + 6);
        check("zero_p1", 64'(log_p[s+1]), 1);
        check("zero_p2", 64'(log_p[s+2]), 0);
        check("zero_p3", 64'(log_p[s+3]), 1);
        check("zero_d4", 64'(log_d[s+4]), 1);

        // Zero pulse count.
        s = cyc;
        drive_start(5, 3, 3, 0);
        wait_until(s + 4);
        check("cnt0_d1", 64'(log_d[s+1]), 1);
        check("cnt0_b1", 64'(log_b[s+1]), 0);
        check("cnt0_p2", 64'(log_p[s+2]), 0);
        check("cnt0_sent", 64'(log_s[s+1]), 0);

        // Abort with ignored re-starts.
        s = cyc; e0 = edge_cnt;
        drive_start(0, 4, 4, 5);
        wait_until(s + 2);
        delay = 7; high_cycles = 1; start = 1'b1; tick(1); start = 1'b0;
        wait_until(s + 6);
        start = 1'b1; tick(1); start = 1'b0;
        wait_until(s + 10);
        abort = 1'b1; tick(1); abort = 1'b0;
        wait_until(s + 20);
        nd = 0;
        for (int i = 0; i < 20; i++) nd += int'(log_d[s+i]);
        check("abort_p5", 64'(log_p[s+5]), 0);
        check("abort_p10", 64'(log_p[s+10]), 1);
        check("abort_p11", 64'(log_p[s+11]), 0);
        check("abort_a11", 64'(log_a[s+11]), 1);
        check("abort_a12", 64'(log_a[s+12]), 0);
        check("abort_sent", 64'(log_s[s+11]), 2);
        check("abort_no_done", 64'(nd), 0);
        check("abort_edges", 64'(edge_cnt - e0), 2);

        // Reset mid-burst.
        s = cyc;
        drive_start(3, 2, 1, 3);
        wait_until(s + 6);
        reset = 1'b1; tick(1); reset = 1'b0;
        wait_until(s + 14);
        check("rstmid_p7", 64'(log_p[s+7]), 0);
        check("rstmid_b7", 64'(log_b[s+7]), 0);
        check("rstmid_s7", 64'(log_s[s+7]), 0);
        check("rstmid_d12", 64'(log_d[s+12]), 0);

        // start and abort together in IDLE.
        s = cyc;
        abort = 1'b1;
        drive_start(0, 1, 1, 1);
        abort = 1'b0;
        wait_until(s + 4);
        check("sa_b1", 64'(log_b[s+1]), 0);
        check("sa_p1", 64'(log_p[s+1]), 0);
        check("sa_d1", 64'(log_d[s+1]), 0);

        // start accepted in the done cycle.
        s = cyc;
        drive_start(3, 2, 1, 3);
        wait_until(s + 12);
        drive_start(0, 1, 1, 1);
        wait_until(s + 17);
        check("redo_d12", 64'(log_d[s+12]), 1);
        check("redo_p13", 64'(log_p[s+13]), 1);
        check("redo_s13", 64'(log_s[s+13]), 1);
        check("redo_d14", 64'(log_d[s+14]), 1);

        // Further directed configurations, checked by the model.
        for (int i = 0; i < 3; i++) begin
            s = cyc; e0 = edge_cnt;
            drive_start(cfg[i][0], cfg[i][1], cfg[i][2], cfg[i][3]);
            wait_until(s + 6 + cfg[i][0] + cfg[i][3] * (cfg[i][1] + cfg[i][2] + 1));
            check("table_edges", 64'(edge_cnt - e0), 64'(cfg[i][3]));
        end

        tick(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
